// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start/data/parity/stop deserialiser with runtime framing config.
// Latency: rx_done_tick one clock after the stop-bit window closes (plus 2-clock input sync).
// No backpressure: rx_done_tick is a single-clock pulse; the consumer must take it that cycle.
module uart_rx_core #(
    parameter int DBIT     = 8,
    parameter int DVSR_BIT = 8,
    parameter int TICK_BIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    input  logic [3:0]          dbit,
    input  logic [1:0]          pbit,
    input  logic [TICK_BIT-1:0] sb_tick,
    input  logic [TICK_BIT-1:0] os_tick,
    input  logic [DVSR_BIT-1:0] dvsr,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_done_tick,
    output logic                e_parity,
    output logic                e_frame,
    output logic                rx_busy
);

    localparam int IDXW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [DVSR_BIT-1:0]  baud_cnt, dvsr_m1;
    logic                 tick;
    logic [TICK_BIT-1:0]  s, s_nxt;
    logic [3:0]           n, n_nxt;
    logic [DBIT-1:0]      data, data_nxt;
    logic                 par_err, par_err_nxt;
    logic                 stop_err, stop_err_nxt;
    logic                 armed, armed_nxt;
    logic [3:0]           dbit_q, dbit_q_nxt;
    logic [1:0]           pbit_q, pbit_q_nxt;
    logic [TICK_BIT-1:0]  sb_q, sb_q_nxt;
    logic [TICK_BIT-1:0]  os_q, os_q_nxt;
    logic [DBIT-1:0]      r_data_nxt;
    logic                 done_nxt, e_parity_nxt, e_frame_nxt;
    logic [TICK_BIT-1:0]  os_m1, half_m1, sb_m1;
    logic                 stop_sample, stop_bad;

    // Two-flop synchroniser on the asynchronous line; idles high out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // A divisor of 0 behaves like 1, so the tick fires every clock.
    assign dvsr_m1 = (dvsr == '0) ? '0 : dvsr - DVSR_BIT'(1);
    assign tick    = (baud_cnt >= dvsr_m1);

    // Free-running oversample tick generator; >= keeps it sane if dvsr shrinks on the fly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + DVSR_BIT'(1);
        end
    end

    assign os_m1       = os_q - TICK_BIT'(1);
    assign half_m1     = (os_q >> 1) - TICK_BIT'(1);
    assign sb_m1       = sb_q - TICK_BIT'(1);
    // Stops no longer than one bit are sampled at their end; longer ones at one bit time.
    assign stop_sample = (sb_q <= os_q) ? (s == sb_m1) : (s == os_m1);
    assign stop_bad    = stop_sample ? ~rx_s : stop_err;
    assign rx_busy     = (state != IDLE);

    // State register, counters, latched frame config and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            data         <= '0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
            armed        <= 1'b1;
            dbit_q       <= '0;
            pbit_q       <= '0;
            sb_q         <= '0;
            os_q         <= '0;
            r_data       <= '0;
            rx_done_tick <= 1'b0;
            e_parity     <= 1'b0;
            e_frame      <= 1'b0;
        end else begin
            state        <= state_nxt;
            s            <= s_nxt;
            n            <= n_nxt;
            data         <= data_nxt;
            par_err      <= par_err_nxt;
            stop_err     <= stop_err_nxt;
            armed        <= armed_nxt;
            dbit_q       <= dbit_q_nxt;
            pbit_q       <= pbit_q_nxt;
            sb_q         <= sb_q_nxt;
            os_q         <= os_q_nxt;
            r_data       <= r_data_nxt;
            rx_done_tick <= done_nxt;
            e_parity     <= e_parity_nxt;
            e_frame      <= e_frame_nxt;
        end
    end

    // Next-state logic: walk the frame on oversample ticks, publish results on stop exit.
    always_comb begin
        state_nxt    = state;
        s_nxt        = s;
        n_nxt        = n;
        data_nxt     = data;
        par_err_nxt  = par_err;
        stop_err_nxt = stop_err;
        // A break must see the line return high before another start is accepted.
        armed_nxt    = armed | rx_s;
        dbit_q_nxt   = dbit_q;
        pbit_q_nxt   = pbit_q;
        sb_q_nxt     = sb_q;
        os_q_nxt     = os_q;
        r_data_nxt   = r_data;
        done_nxt     = 1'b0;
        e_parity_nxt = e_parity;
        e_frame_nxt  = e_frame;

        case (state)
            IDLE: begin
                if (!rx_s && armed) begin
                    state_nxt    = START;
                    s_nxt        = '0;
                    n_nxt        = '0;
                    data_nxt     = '0;
                    par_err_nxt  = 1'b0;
                    stop_err_nxt = 1'b0;
                    dbit_q_nxt   = dbit;
                    pbit_q_nxt   = pbit;
                    sb_q_nxt     = sb_tick;
                    os_q_nxt     = os_tick;
                end
            end
            START: begin
                if (tick) begin
                    if (s == half_m1) begin
                        s_nxt     = '0;
                        n_nxt     = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end else begin
                        s_nxt = s + TICK_BIT'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == os_m1) begin
                        s_nxt = '0;
                        if (32'(n) < DBIT) begin
                            data_nxt[n[IDXW-1:0]] = rx_s;
                        end
                        if (n == dbit_q - 4'd1) begin
                            state_nxt = (pbit_q == 2'd1 || pbit_q == 2'd2) ? PARITY : STOP;
                        end else begin
                            n_nxt = n + 4'd1;
                        end
                    end else begin
                        s_nxt = s + TICK_BIT'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (s == os_m1) begin
                        s_nxt       = '0;
                        state_nxt   = STOP;
                        // Odd parity expects an overall XOR of 1, even expects 0.
                        par_err_nxt = (^data) ^ rx_s ^ (pbit_q == 2'd2);
                    end else begin
                        s_nxt = s + TICK_BIT'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_sample) begin
                        stop_err_nxt = ~rx_s;
                    end
                    if (s == sb_m1) begin
                        s_nxt        = '0;
                        state_nxt    = IDLE;
                        done_nxt     = 1'b1;
                        r_data_nxt   = data;
                        e_parity_nxt = par_err;
                        e_frame_nxt  = stop_bad;
                        if (stop_bad) begin
                            armed_nxt = 1'b0;
                        end
                    end else begin
                        s_nxt = s + TICK_BIT'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [3:0] dbit;
    logic [1:0] pbit;
    logic [7:0] sb_tick;
    logic [7:0] os_tick;
    logic [7:0] dvsr;
    logic [7:0] r_data;
    logic       rx_done_tick;
    logic       e_parity;
    logic       e_frame;
    logic       rx_busy;

    int         checks;
    int         errors;
    int         done_cnt;
    time        t_start;
    time        t_done;
    logic [9:0] exp_q[$];

    uart_rx_core #(.DBIT(8), .DVSR_BIT(8), .TICK_BIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .dbit         (dbit),
        .pbit         (pbit),
        .sb_tick      (sb_tick),
        .os_tick      (os_tick),
        .dvsr         (dvsr),
        .r_data       (r_data),
        .rx_done_tick (rx_done_tick),
        .e_parity     (e_parity),
        .e_frame      (e_frame),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every completed frame is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rx_done_tick) begin
            logic [9:0] e;
            done_cnt++;
            t_done = $time;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got data=%h ep=%b ef=%b, no frame expected",
                         r_data, e_parity, e_frame);
            end else begin
                e = exp_q.pop_front();
                if ({r_data, e_parity, e_frame} !== e) begin
                    errors++;
                    $display("FAIL frame_result got data=%h ep=%b ef=%b expected data=%h ep=%b ef=%b",
                             r_data, e_parity, e_frame, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    function automatic int bit_clks();
        return ((dvsr == 0) ? 1 : int'(dvsr)) * int'(os_tick);
    endfunction

    // Drives one frame starting at the current negedge; returns on a negedge.
    task automatic send_frame(input logic [7:0] d, input int nb, input int pm,
                              input bit par_bad, input bit stop_v);
        int         bc;
        logic [7:0] m;
        logic       p;
        bc = bit_clks();
        m  = d;
        if (nb == 7) m[7] = 1'b0;
        p = ^m;
        if (pm == 2) p = ~p;
        if (par_bad) p = ~p;
        exp_q.push_back({m, (pm == 1 || pm == 2) ? par_bad : 1'b0, ~stop_v});
        rx = 1'b0;
        t_start = $time;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx = m[i];
            repeat (bc) @(negedge clk);
        end
        if (pm == 1 || pm == 2) begin
            rx = p;
            repeat (bc) @(negedge clk);
        end
        rx = stop_v;
        repeat (int'(sb_tick) * ((dvsr == 0) ? 1 : int'(dvsr))) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input int limit, output bit ok);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        ok = (exp_q.size() == 0);
        exp_q.delete();
    endtask

    task automatic cfg(input int db, input int pb, input int sb, input int os, input int dv);
        dbit    = 4'(db);
        pbit    = 2'(pb);
        sb_tick = 8'(sb);
        os_tick = 8'(os);
        dvsr    = 8'(dv);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx    = 1'b1;
        cfg(8, 0, 16, 16, 2);
        repeat (3) @(negedge clk);
        checks++;
        if (r_data !== 8'h00) begin errors++; $display("FAIL reset_r_data got=%h expected=00", r_data); end
        checks++;
        if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got=%b expected=0", rx_done_tick); end
        checks++;
        if (e_parity !== 1'b0) begin errors++; $display("FAIL reset_e_parity got=%b expected=0", e_parity); end
        checks++;
        if (e_frame !== 1'b0) begin errors++; $display("FAIL reset_e_frame got=%b expected=0", e_frame); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected=0", rx_busy); end
        reset = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_8n1();
        int d0, lat;
        bit ok;
        cfg(8, 0, 16, 16, 2);
        d0 = done_cnt;
        send_frame(8'hA5, 8, 0, 1'b0, 1'b1);
        wait_drain(200, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL 8n1_timeout got=no_done expected=done"); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL 8n1_pulses got=%0d expected=1", done_cnt - d0); end
        lat = int'((t_done - t_start) / 10);
        checks++;
        if (lat < 296 || lat > 324) begin errors++; $display("FAIL 8n1_duration got=%0d expected=296..324", lat); end
    endtask

    task automatic test_frame_err();
        bit ok;
        cfg(8, 0, 16, 16, 2);
        send_frame(8'hA5, 8, 0, 1'b0, 1'b0);
        wait_drain(200, ok);
        checks++;
        if (!ok || e_frame !== 1'b1) begin errors++; $display("FAIL frame_err_set got=%b expected=1", e_frame); end
        repeat (40) @(negedge clk);
        send_frame(8'h5A, 8, 0, 1'b0, 1'b1);
        wait_drain(200, ok);
        checks++;
        if (!ok || e_frame !== 1'b0) begin errors++; $display("FAIL frame_err_clear got=%b expected=0", e_frame); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int  d0;
        bit  ok;
        logic [7:0] v;
        v = 8'h3C;
        cfg(8, 0, 16, 16, 2);
        d0 = done_cnt;
        rx = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = v[i];
            repeat (32) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy got=%b expected=1", rx_busy); end
        reset = 1'b0;
        #1;
        checks++;
        if ({r_data, rx_done_tick, e_parity, e_frame, rx_busy} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset got data=%h done=%b ep=%b ef=%b busy=%b expected all 0",
                     r_data, rx_done_tick, e_parity, e_frame, rx_busy);
        end
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (400) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL aborted_pulse got=%0d expected=0", done_cnt - d0); end
        send_frame(8'h3C, 8, 0, 1'b0, 1'b1);
        wait_drain(200, ok);
        checks++;
        if (!ok || r_data !== 8'h3C) begin errors++; $display("FAIL after_reset got=%h expected=3c", r_data); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_glitch();
        int  d0, k;
        bit  seen_high;
        cfg(8, 0, 16, 16, 2);
        d0 = done_cnt;
        seen_high = 1'b0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        k = 3;
        while (k < 40 && !(seen_high && !rx_busy)) begin
            if (rx_busy) seen_high = 1'b1;
            @(negedge clk);
            k++;
        end
        checks++;
        if (!seen_high) begin errors++; $display("FAIL glitch_busy_rise got=0 expected=1"); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got=%b expected=0 within 40 clocks", rx_busy); end
        repeat (400) @(negedge clk);
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL glitch_pulse got=%0d expected=0", done_cnt - d0); end
    endtask

    task automatic test_break();
        int d0;
        cfg(8, 0, 16, 16, 2);
        d0 = done_cnt;
        exp_q.push_back({8'h00, 1'b0, 1'b1});
        rx = 1'b0;
        repeat (32 * 14) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL break_pulses got=%0d expected=1", done_cnt - d0); end
        checks++;
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_retrigger got busy=%b expected=0", rx_busy); end
        rx = 1'b1;
        repeat (64) @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_parity_even();
        bit ok;
        cfg(8, 1, 72, 72, 6);
        send_frame(8'h03, 8, 1, 1'b0, 1'b1);
        wait_drain(2000, ok);
        checks++;
        if (!ok || e_parity !== 1'b0) begin errors++; $display("FAIL even_good got ep=%b expected=0", e_parity); end
        repeat (50) @(negedge clk);
        send_frame(8'h03, 8, 1, 1'b1, 1'b1);
        wait_drain(2000, ok);
        checks++;
        if (!ok || e_parity !== 1'b1 || r_data !== 8'h03) begin
            errors++;
            $display("FAIL even_bad got ep=%b data=%h expected ep=1 data=03", e_parity, r_data);
        end
        repeat (50) @(negedge clk);
    endtask

    task automatic test_7o15_back_to_back();
        int  d0;
        bit  ok;
        cfg(7, 2, 24, 16, 162);
        d0 = done_cnt;
        send_frame(8'h55, 7, 2, 1'b0, 1'b1);
        send_frame(8'h7F, 7, 2, 1'b0, 1'b1);
        wait_drain(5000, ok);
        repeat (50) @(negedge clk);
        checks++;
        if (!ok || done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_pulses got=%0d expected=2", done_cnt - d0); end
        checks++;
        if (r_data !== 8'h7F || e_parity !== 1'b0 || e_frame !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last got data=%h ep=%b ef=%b expected 7f 0 0", r_data, e_parity, e_frame);
        end
        checks++;
        if (r_data[7] !== 1'b0) begin errors++; $display("FAIL b2b_msb got=%b expected=0", r_data[7]); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        t_start  = 0;
        t_done   = 0;
        test_reset();
        test_8n1();
        test_frame_err();
        test_reset_mid();
        test_glitch();
        test_break();
        test_parity_even();
        test_7o15_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
